// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter_pkg
//  Brief    : Shared register-file write-back types and constants.
//  Revision : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int                REG_AW   = 5;
    localparam int                REG_DW   = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [REG_DW-1:0] wdata;
    } wb_req;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_queue
//  Brief    : Long-latency result FIFO with per-entry valid/dead bits and an
//             address-match kill port for write-after-write suppression.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_queue
    import rf_wb_arbiter_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  wb_req             push_req,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_addr,
    output wb_req             head_req,
    output logic              head_valid,
    output logic              head_dead,
    output logic              full,
    output logic [CW-1:0]     count
);

    wb_req             r_mem [QDEPTH];
    logic [QDEPTH-1:0] r_valid;
    logic [QDEPTH-1:0] r_dead;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    // Kill first, then pop/push, so a slot being pushed this cycle stays live.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid  <= '0;
            r_dead   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (kill_en && r_valid[i] && (r_mem[i].waddr == kill_addr))
                    r_dead[i] <= 1'b1;
            end
            if (pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_dead[r_rd_ptr]  <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_dead[r_wr_ptr]  <= 1'b0;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= push_req;
    end

    assign head_req   = r_mem[r_rd_ptr];
    assign head_valid = r_valid[r_rd_ptr];
    assign head_dead  = r_valid[r_rd_ptr] & r_dead[r_rd_ptr];
    assign full       = (r_count == CW'(QDEPTH));
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wb_arbiter
//  Brief    : Merges pipeline and long-latency write-backs onto the single
//             register-file write port with WAW ordering and starvation bound.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter  int QDEPTH       = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CW           = $clog2(QDEPTH) + 1,
    localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [REG_DW-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_waddr,
    input  logic [REG_DW-1:0] lu_wdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_DW-1:0] rf_wdata,
    output logic [CW-1:0]     q_count
);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] w_starve_nxt;

    wb_req         w_head;
    logic          w_head_valid;
    logic          w_head_dead;
    logic          w_head_live;
    logic          w_full;
    logic          w_pipe_ok;
    logic          w_push;
    wb_req         w_push_req;
    logic          w_pop;
    logic          w_kill;
    logic          w_issue;
    wb_req         w_issue_req;
    logic          w_starve_inc;
    logic [CW-1:0] w_count_nxt;

    // A pipe write to r0 is treated as an empty pipe slot.
    assign w_pipe_ok   = pipe_valid && (pipe_waddr != REG_ZERO);
    assign w_head_live = w_head_valid && !w_head_dead;
    assign lu_ready    = !w_full;
    assign w_push      = lu_valid && !w_full && (lu_waddr != REG_ZERO);
    assign pipe_stall  = (r_state == FORCE);
    assign w_count_nxt = q_count + CW'(w_push) - CW'(w_pop);

    always_comb begin
        w_push_req.waddr = lu_waddr;
        w_push_req.wdata = lu_wdata;
    end

    rf_wb_queue #(
        .QDEPTH     (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (w_push),
        .push_req   (w_push_req),
        .pop        (w_pop),
        .kill_en    (w_kill),
        .kill_addr  (pipe_waddr),
        .head_req   (w_head),
        .head_valid (w_head_valid),
        .head_dead  (w_head_dead),
        .full       (w_full),
        .count      (q_count)
    );

    // Write-port selection; a dead head is discarded without taking the slot.
    always_comb begin
        w_issue       = 1'b0;
        w_issue_req   = '0;
        w_pop         = w_head_dead;
        w_kill        = 1'b0;
        w_starve_inc  = 1'b0;
        if (r_state == FORCE) begin
            if (w_head_live) begin
                w_issue     = 1'b1;
                w_issue_req = w_head;
                w_pop       = 1'b1;
            end
        end else if (w_pipe_ok) begin
            w_issue           = 1'b1;
            w_issue_req.waddr = pipe_waddr;
            w_issue_req.wdata = pipe_wdata;
            w_kill            = 1'b1;
            w_starve_inc      = w_head_live;
        end else if (w_head_live) begin
            w_issue     = 1'b1;
            w_issue_req = w_head;
            w_pop       = 1'b1;
        end
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || (w_count_nxt == '0))
            w_starve_nxt = '0;
        else if (w_starve_inc && (r_starve != SW'(STARVE_LIMIT)))
            w_starve_nxt = r_starve + 1'b1;

        w_state_nxt = r_state;
        case (r_state)
            NORMAL:  if (w_starve_nxt == SW'(STARVE_LIMIT)) w_state_nxt = FORCE;
            FORCE:   if (q_count == '0)                     w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= NORMAL;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= w_issue;
            if (w_issue) begin
                rf_waddr <= w_issue_req.waddr;
                rf_wdata <= w_issue_req.wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wb_arbiter
//  Brief    : Directed self-checking bench with a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int QDEPTH       = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int CW           = $clog2(QDEPTH) + 1;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          pipe_valid = 1'b0;
    logic [4:0]    pipe_waddr = '0;
    logic [31:0]   pipe_wdata = '0;
    logic          lu_valid   = 1'b0;
    logic [4:0]    lu_waddr   = '0;
    logic [31:0]   lu_wdata   = '0;
    logic          pipe_stall;
    logic          lu_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [CW-1:0] q_count;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .QDEPTH       (QDEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pipe_valid (pipe_valid),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .q_count    (q_count)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          dead;
    } ent_t;

    ent_t        mq[$];
    bit          m_force  = 1'b0;
    int          m_starve = 0;
    bit          m_we     = 1'b0;
    logic [4:0]  m_waddr  = '0;
    logic [31:0] m_wdata  = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: compare the outputs of the last edge, then advance with the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin : model
        int   n0;
        bit   was_force, pipe_ok, push_ok, head_live, popped, pipe_won;
        ent_t e;
        if (!resetn) begin
            mq.delete();
            m_force  = 1'b0;
            m_starve = 0;
            m_we     = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
        end
        check("rf_we", rf_we, m_we);
        if (m_we) begin
            check("rf_waddr", rf_waddr, m_waddr);
            check("rf_wdata", rf_wdata, m_wdata);
        end
        check("r0_write", rf_we && (rf_waddr == 5'd0), 0);
        check("q_count", q_count, mq.size());
        check("lu_ready", lu_ready, mq.size() < QDEPTH);
        check("pipe_stall", pipe_stall, m_force);
        if (resetn) begin
            n0        = mq.size();
            was_force = m_force;
            pipe_ok   = !m_force && pipe_valid && (pipe_waddr != 5'd0);
            push_ok   = lu_valid && (n0 < QDEPTH) && (lu_waddr != 5'd0);
            head_live = (n0 > 0) && !mq[0].dead;
            popped    = 1'b0;
            pipe_won  = 1'b0;
            m_we      = 1'b0;
            if (n0 > 0 && mq[0].dead) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end else if (head_live && (m_force || !pipe_ok)) begin
                m_we    = 1'b1;
                m_waddr = mq[0].a;
                m_wdata = mq[0].d;
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (pipe_ok) begin
                m_we     = 1'b1;
                m_waddr  = pipe_waddr;
                m_wdata  = pipe_wdata;
                pipe_won = 1'b1;
                foreach (mq[i]) if (mq[i].a == pipe_waddr) mq[i].dead = 1'b1;
            end
            if (push_ok) begin
                e.a = lu_waddr; e.d = lu_wdata; e.dead = 1'b0;
                mq.push_back(e);
            end
            if (popped || mq.size() == 0)
                m_starve = 0;
            else if (pipe_won && head_live && m_starve < STARVE_LIMIT)
                m_starve++;
            if (was_force) begin
                if (n0 == 0) m_force = 1'b0;
            end else if (m_starve == STARVE_LIMIT) begin
                m_force = 1'b1;
            end
        end
    end

    task automatic step(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_valid = pv; pipe_waddr = pa; pipe_wdata = pd;
        lu_valid   = lv; lu_waddr   = la; lu_wdata   = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        idle();

        // Reset with three queued entries discards them
        for (int i = 0; i < 3; i++)
            step(1, 5'd1, 32'h11, 1, 5'(10 + i), 32'hA0 + i);
        check("t1_fill", q_count, 3);
        idle();
        step(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
        pipe_valid = 1'b0;
        #1 resetn = 1'b0;
        #2;
        check("t1_rst_q", q_count, 0);
        check("t1_rst_rdy", lu_ready, 1);
        check("t1_rst_stall", pipe_stall, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t1_no_we", rf_we, 0);
        end

        // Single lu push: two cycles to rf_we
        step(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234);
        check("t2_q1", q_count, 1);
        check("t2_we0", rf_we, 0);
        idle();
        check("t2_we", rf_we, 1);
        check("t2_addr", rf_waddr, 5);
        check("t2_data", rf_wdata, 32'h1234);
        check("t2_q0", q_count, 0);

        // WAW kill, then lu push to r0 is swallowed
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'hAAAA);
        step(1, 5'd7, 32'hBBBB, 0, 5'd0, 32'd0);
        check("t3_data", rf_wdata, 32'hBBBB);
        check("t3_qdead", q_count, 1);
        idle();
        check("t3_deadpop", rf_we, 0);
        check("t3_q0", q_count, 0);
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
        check("t3_r0q", q_count, 0);
        idle();
        check("t3_r0we", rf_we, 0);

        // Fill to full, refused push during a pop, accepted next cycle
        for (int i = 0; i < 4; i++)
            step(1, 5'(1 + i), 32'h100 + i, 1, 5'(20 + i), 32'h200 + i);
        check("t4_full_q", q_count, 4);
        check("t4_full_rdy", lu_ready, 0);
        step(0, 5'd0, 32'd0, 1, 5'd24, 32'h224);
        check("t4_refused", q_count, 3);
        check("t4_pop20", rf_waddr, 20);
        step(0, 5'd0, 32'd0, 1, 5'd24, 32'h224);
        check("t4_accept", q_count, 3);
        check("t4_pop21", rf_waddr, 21);
        repeat (3) idle();
        check("t4_last", rf_wdata, 32'h224);
        check("t4_q0", q_count, 0);

        // Starvation forces the queued head out
        step(1, 5'd1, 32'h11, 1, 5'd9, 32'h99);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            step(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
            check("t5_stall", pipe_stall, (i == STARVE_LIMIT - 1));
        end
        step(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
        check("t5_r9addr", rf_waddr, 9);
        check("t5_r9data", rf_wdata, 32'h99);
        check("t5_hold", pipe_stall, 1);
        step(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
        check("t5_release", pipe_stall, 0);
        check("t5_gap", rf_we, 0);
        step(1, 5'd1, 32'h11, 0, 5'd0, 32'd0);
        check("t5_resume", rf_waddr, 1);
        idle();

        // Pipe write to r0 lets the live head through
        step(0, 5'd0, 32'd0, 1, 5'd3, 32'h55);
        step(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
        check("t6_addr", rf_waddr, 3);
        check("t6_data", rf_wdata, 32'h55);

        // Same-cycle lu push and pipe issue to one register: new entry survives
        step(0, 5'd0, 32'd0, 1, 5'd8, 32'h81);
        step(1, 5'd8, 32'h82, 1, 5'd8, 32'h83);
        check("t7_q2", q_count, 2);
        idle();
        check("t7_dead", rf_we, 0);
        idle();
        check("t7_live", rf_wdata, 32'h83);
        repeat (2) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
